dlatch_write_arbiter: RTL and testbench

Round-robin write arbiter and sequencer for a shared enabled storage register. Up to NREQ requesters compete to write a WIDTH-bit word into one register that exposes true (`q`) and complemented (`qbar`) outputs. The block grants one requester at a time, generates the one-cycle write enable, holds ownership for a programmable lock period, and acknowledges completion. It sits between requesting datapath blocks and the shared register cell.

---
 rtl/dlatch_write_arbiter_pkg.sv | 38 +++
 rtl/dlatch_write_arbiter_enabled_reg_cell.sv | 24 ++
 rtl/dlatch_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_dlatch_write_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dlatch_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin write arbiter.
package dlatch_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    // Returns the first set request at or after last+1 (mod nreq); supports up to 16 requesters.
    function automatic logic [3:0] rr_select(input logic [15:0] req_v,
                                             input logic [3:0]  last_v,
                                             input logic [4:0]  nreq);
        logic [3:0] sel;
        logic       found;
        logic [4:0] idx;
        sel   = 4'd0;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = {1'b0, last_v} + 5'(i);
            if (idx >= nreq) begin
                idx = idx - nreq;
            end else begin
                idx = idx;
            end
            if ((5'(i) <= nreq) && !found && req_v[idx[3:0]]) begin
                sel   = idx[3:0];
                found = 1'b1;
            end else begin
                sel   = sel;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/dlatch_write_arbiter_enabled_reg_cell.sv
// Enabled storage register with true and complemented outputs updated together.
module enabled_reg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    // Both polarities load on the same edge so qbar is never incoherent with q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= {WIDTH{1'b0}};
            qbar <= {WIDTH{1'b1}};
        end else if (enable) begin
            q    <= d;
            qbar <= ~d;
        end
    end

endmodule

// File: rtl/dlatch_write_arbiter.sv
// Round-robin write arbiter/sequencer for a shared enabled register.
// Optional macro DLATCH_ARB_PARITY_EN adds the registered even-parity output q_par.
module dlatch_write_arbiter
    import dlatch_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qbar
`ifdef DLATCH_ARB_PARITY_EN
    ,
    output logic                     q_par
`endif
);

    localparam int OW    = $clog2(NREQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

    arb_state_t        state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [OW-1:0]     owner_r, owner_next_s;
    logic [OW-1:0]     last_r, last_next_s;
    logic [NREQ-1:0]   gnt_r, gnt_next_s;
    logic [NREQ-1:0]   ack_r, ack_next_s;
    logic              busy_r, busy_next_s;
    logic              write_en_s;
    logic [WIDTH-1:0]  d_s;

    // State register plus registered outputs; last resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            owner_r <= {OW{1'b0}};
            last_r  <= OW'(NREQ - 1);
            gnt_r   <= {NREQ{1'b0}};
            ack_r   <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            owner_r <= owner_next_s;
            last_r  <= last_next_s;
            gnt_r   <= gnt_next_s;
            ack_r   <= ack_next_s;
            busy_r  <= busy_next_s;
        end
    end

    // Next-state, lock counter and ownership selection.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        owner_next_s = owner_r;
        last_next_s  = last_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    owner_next_s = OW'(rr_select(16'(req), 4'(last_r), 5'(NREQ)));
                    last_next_s  = owner_next_s;
                    state_next_s = WRITE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                state_next_s = HOLD;
                cnt_next_s   = CNT_W'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so gnt/ack/busy land registered in the right cycle.
    always_comb begin
        gnt_next_s  = {NREQ{1'b0}};
        ack_next_s  = {NREQ{1'b0}};
        busy_next_s = (state_next_s != IDLE);
        write_en_s  = (state_r == WRITE);
        if (state_next_s != IDLE) begin
            gnt_next_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_next_s;
        end else begin
            gnt_next_s = {NREQ{1'b0}};
        end
        if ((state_next_s == HOLD) && (cnt_next_s == {CNT_W{1'b0}})) begin
            ack_next_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_next_s;
        end else begin
            ack_next_s = {NREQ{1'b0}};
        end
    end

    assign d_s   = wdata[int'(owner_r)*WIDTH +: WIDTH];
    assign gnt   = gnt_r;
    assign ack   = ack_r;
    assign owner = owner_r;
    assign busy  = busy_r;

    enabled_reg_cell #(.WIDTH(WIDTH)) u_cell (
        .clk    (clk),
        .rst    (rst),
        .enable (write_en_s),
        .d      (d_s),
        .q      (q),
        .qbar   (qbar)
    );

`ifdef DLATCH_ARB_PARITY_EN
    logic q_par_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Parity loads on the same edge as the stored word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_par_r <= 1'b0;
        end else if (write_en_s) begin
            q_par_r <= even_parity(d_s);
        end
    end

    assign q_par = q_par_r;
`endif

endmodule

// File: tb/tb_dlatch_write_arbiter.sv
// Directed self-checking bench for dlatch_write_arbiter (NREQ=4, WIDTH=8, HOLD_CYCLES=2).
module tb_dlatch_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  qbar;
`ifdef DLATCH_ARB_PARITY_EN
    logic        q_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dlatch_write_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .owner (owner),
        .busy  (busy),
        .q     (q),
        .qbar  (qbar)
`ifdef DLATCH_ARB_PARITY_EN
        ,
        .q_par (q_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complement coherence on every falling edge.
    always @(negedge clk) begin
        check_val("qbar_coherent", {24'd0, qbar}, {24'd0, ~q});
    end

    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_q   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        wdata = 32'h0;
        tick();
        tick();
        check_val("rst_gnt",   {28'd0, gnt},   32'h0);
        check_val("rst_ack",   {28'd0, ack},   32'h0);
        check_val("rst_busy",  {31'd0, busy},  32'h0);
        check_val("rst_owner", {30'd0, owner}, 32'h0);
        check_val("rst_q",     {24'd0, q},     32'h00);
        check_val("rst_qbar",  {24'd0, qbar},  32'hFF);
        rst = 1'b0;
        tick();
        check_val("idle_gnt", {28'd0, gnt}, 32'h0);

        // Single request from requester 1
        req = 4'b0010;
        wdata[8 +: 8] = 8'hA5;
        tick();
        check_val("s1_gnt",   {28'd0, gnt},   32'h2);
        check_val("s1_busy",  {31'd0, busy},  32'h1);
        check_val("s1_owner", {30'd0, owner}, 32'h1);
        check_val("s1_q",     {24'd0, q},     32'h00);
        req = 4'b0000;
        tick();
        check_val("s2_q",    {24'd0, q},    32'hA5);
        check_val("s2_qbar", {24'd0, qbar}, 32'h5A);
        check_val("s2_ack",  {28'd0, ack},  32'h0);
        check_val("s2_gnt",  {28'd0, gnt},  32'h2);
        tick();
        check_val("s3_ack", {28'd0, ack}, 32'h2);
        check_val("s3_busy", {31'd0, busy}, 32'h1);
        tick();
        check_val("s4_busy", {31'd0, busy}, 32'h0);
        check_val("s4_gnt",  {28'd0, gnt},  32'h0);
        check_val("s4_ack",  {28'd0, ack},  32'h0);

        // Hold path: nothing requested for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("hold_q",    {24'd0, q},    32'hA5);
            check_val("hold_qbar", {24'd0, qbar}, 32'h5A);
            check_val("hold_gnt",  {28'd0, gnt},  32'h0);
        end

        // Early drop: requester 2 asserts for one cycle only
        req = 4'b0100;
        wdata[16 +: 8] = 8'h3C;
        tick();
        req = 4'b0000;
        check_val("drop_gnt", {28'd0, gnt}, 32'h4);
        tick();
        check_val("drop_q", {24'd0, q}, 32'h3C);
        tick();
        check_val("drop_ack", {28'd0, ack}, 32'h4);
        tick();
        check_val("drop_idle", {31'd0, busy}, 32'h0);

        // Contention from a fresh reset: rotation 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wdata = 32'h44332211;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("rr_gnt",  {28'd0, gnt}, {28'd0, exp_gnt[k]});
            check_val("rr_ack0", {28'd0, ack}, 32'h0);
            tick();
            check_val("rr_q", {24'd0, q}, {24'd0, exp_q[k]});
            tick();
            check_val("rr_ack", {28'd0, ack}, {28'd0, exp_gnt[k]});
            tick();
            check_val("rr_gap_gnt",  {28'd0, gnt},  32'h0);
            check_val("rr_gap_busy", {31'd0, busy}, 32'h0);
            if (k == 4) begin
                req = 4'b0000;
            end
        end

        // Reset in the middle of HOLD for requester 1
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check_val("mh_gnt", {28'd0, gnt}, 32'h2);
        tick();
        check_val("mh_q", {24'd0, q}, 32'h22);
        rst = 1'b1;
        #1;
        check_val("mh_rst_gnt",  {28'd0, gnt},  32'h0);
        check_val("mh_rst_ack",  {28'd0, ack},  32'h0);
        check_val("mh_rst_busy", {31'd0, busy}, 32'h0);
        check_val("mh_rst_q",    {24'd0, q},    32'h00);
        check_val("mh_rst_qbar", {24'd0, qbar}, 32'hFF);
        tick();
        check_val("mh_no_ack", {28'd0, ack}, 32'h0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        req = 4'b0000;
        check_val("mh_next_gnt", {28'd0, gnt}, 32'h1);
        tick();
        tick();
        tick();
        check_val("mh_done", {31'd0, busy}, 32'h0);

`ifdef DLATCH_ARB_PARITY_EN
        // Parity: 0x07 has three ones, 0x03 has two
        wdata[0 +: 8] = 8'h07;
        wdata[8 +: 8] = 8'h03;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        check_val("par_q07", {24'd0, q},     32'h07);
        check_val("par_1",   {31'd0, q_par}, 32'h1);
        tick();
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check_val("par_hold", {31'd0, q_par}, 32'h1);
        tick();
        check_val("par_q03", {24'd0, q},     32'h03);
        check_val("par_0",   {31'd0, q_par}, 32'h0);
        tick();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
